// File: rtl/h264_dcquant_pkg.sv
// h264_dcquant_pkg: shared widths, MF table, rounding-offset helper and FSM states for the chroma DC quantiser.
package h264_dcquant_pkg;
  localparam int DCQ_IN_W = 16;
  localparam int DCQ_OUT_W = 12;
  localparam int DCQ_SAT = 2047;
  localparam logic [5:0][13:0] DCQ_MF = {14'd7282, 14'd8192, 14'd9362, 14'd10082, 14'd11916, 14'd13107};
  typedef enum logic {IDLE, LOAD} dcq_state_t;
  function automatic logic [31:0] dcq_f(input logic [3:0] qdiv, input logic intra);
    return (32'd1 << (5'd16 + 5'(qdiv))) / (intra ? 32'd3 : 32'd6);
  endfunction
endpackage

// File: rtl/h264_dcquant_fifo.sv
// h264_dcquant_fifo: 4-deep, 12-bit synchronous FIFO with occupancy count.
module h264_dcquant_fifo
  import h264_dcquant_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 push_i,
  input  logic [DCQ_OUT_W-1:0] din_i,
  input  logic                 pop_i,
  output logic [DCQ_OUT_W-1:0] dout_o,
  output logic [2:0]           count_o
);
  logic [DCQ_OUT_W-1:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q] <= din_i;
    if (RESET) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + 2'(push_i);
      rd_q <= rd_q + 2'(pop_i);
      cnt_q <= cnt_q + 3'(push_i) - 3'(pop_i);
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/h264_dcquant.sv
// h264_dcquant: H.264 chroma DC quantiser, 3-stage pipeline into a 4-entry output FIFO; H264DCQ_NZFLAG_EN adds the NZ block flag.
module h264_dcquant
  import h264_dcquant_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [DCQ_IN_W-1:0]  XXIN,
  input  logic [5:0]           QP,
  input  logic                 INTRA,
  output logic                 READYI,
  output logic                 VALID,
  output logic [DCQ_OUT_W-1:0] YYOUT,
  input  logic                 READYO
`ifdef H264DCQ_NZFLAG_EN
  ,output logic                NZ
`endif
);
  dcq_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] qp_q;
  logic intra_q;
  logic s1_v, s2_v, s3_v;
  logic [15:0] s1_abs;
  logic s1_neg, s1_intra, s2_neg;
  logic [3:0] s1_qdiv;
  logic [2:0] s1_qmod;
  logic [31:0] s2_sum;
  logic [4:0] s2_sh;
  logic [DCQ_OUT_W-1:0] s3_z, fifo_dout;
  logic [2:0] fifo_cnt;
  logic accept, pop;
  logic [5:0] qp_c;
  logic intra_c;
  logic [31:0] mag_c;
  logic [10:0] sat_c;
  assign accept = ENABLE && (state_q == LOAD || READYI);
  assign qp_c = state_q == IDLE ? QP : qp_q;
  assign intra_c = state_q == IDLE ? INTRA : intra_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      state_d = cnt_q == 2'd3 ? IDLE : LOAD;
    end
  end
  // Only start a block once nothing is buffered or in flight, so it can never stall.
  always_comb begin
    READYI = state_q == IDLE && fifo_cnt == 3'd0 && !(s1_v || s2_v || s3_v);
  end
  always_ff @(posedge CLK) begin
    if (accept && state_q == IDLE) begin
      qp_q <= QP;
      intra_q <= INTRA;
    end
  end
  // Quantiser parameters travel with each coefficient through the pipeline.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      s3_v <= s2_v;
    end
    s1_neg <= XXIN[DCQ_IN_W-1];
    s1_abs <= XXIN[DCQ_IN_W-1] ? -XXIN : XXIN;
    s1_qdiv <= 4'(qp_c / 6'd6);
    s1_qmod <= 3'(qp_c % 6'd6);
    s1_intra <= intra_c;
    s2_neg <= s1_neg;
    s2_sh <= 5'd16 + 5'(s1_qdiv);
    s2_sum <= 32'(s1_abs) * 32'(DCQ_MF[s1_qmod]) + dcq_f(s1_qdiv, s1_intra);
    s3_z <= s2_neg ? -{1'b0, sat_c} : {1'b0, sat_c};
  end
  assign mag_c = s2_sum >> s2_sh;
  assign sat_c = mag_c > 32'(DCQ_SAT) ? 11'(DCQ_SAT) : mag_c[10:0];
  h264_dcquant_fifo u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (s3_v),
    .din_i   (s3_z),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_cnt)
  );
  assign VALID = fifo_cnt != 3'd0;
  assign pop = VALID && READYO;
  assign YYOUT = VALID ? fifo_dout : '0;
`ifdef H264DCQ_NZFLAG_EN
  logic [1:0] oc_q;
  logic acc_q, nz_q, nzy;
  assign nzy = YYOUT != '0;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      oc_q <= '0;
      acc_q <= 1'b0;
      nz_q <= 1'b0;
    end else if (pop) begin
      oc_q <= oc_q + 2'd1;
      acc_q <= oc_q == 2'd3 ? 1'b0 : acc_q | nzy;
      if (oc_q == 2'd3) nz_q <= acc_q | nzy;
    end
  end
  assign NZ = VALID && oc_q == 2'd3 ? acc_q | nzy : nz_q;
`endif
endmodule
